cmult_sched: RTL

Sequencing controller for the complex-multiply datapath. It computes (a_re + j·a_im)·(q_re + j·q_im) with a single shared signed multiplier, time-multiplexed over four partial products. A start/busy/done handshake lets the supervisory state machine launch a multiply after the four operand words are captured, then display the results.

---
 rtl/cmult_pkg.sv | 25 ++
 rtl/cmult_sched_mult_unit.sv | 28 ++
 rtl/cmult_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/cmult_pkg.sv
// Shared types and width helpers for the complex-multiply sequencer.
package cmult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    FIN  = 3'd5
  } state_t;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned res_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned PROD_W    = prod_w(WIDTH_DEF);
  localparam int unsigned RES_W     = res_w(WIDTH_DEF);

endpackage

// File: rtl/cmult_sched_mult_unit.sv
// Shared signed WIDTH x WIDTH multiplier with a registered full-width product.
module mult_unit
  import cmult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [WIDTH-1:0]    i_a,
  input  logic signed [WIDTH-1:0]    i_b,
  output logic signed [2*WIDTH-1:0]  o_p
);

  localparam int unsigned PW = prod_w(WIDTH);

  logic signed [PW-1:0] r_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= '0;
    end else begin
      r_p <= PW'(i_a) * PW'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/cmult_sched.sv
// Complex multiply sequencer: four partial products through one shared multiplier.
module cmult_sched
  import cmult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  re_a,
  input  logic signed [WIDTH-1:0]  im_a,
  input  logic signed [WIDTH-1:0]  re_q,
  input  logic signed [WIDTH-1:0]  im_q,
  output logic                     busy,
  output logic                     done,
  output logic signed [2*WIDTH:0]  re_res,
  output logic signed [2*WIDTH:0]  im_res
);

  localparam int unsigned PW = prod_w(WIDTH);
  localparam int unsigned RW = res_w(WIDTH);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_re_a;
  logic signed [WIDTH-1:0] r_im_a;
  logic signed [WIDTH-1:0] r_re_q;
  logic signed [WIDTH-1:0] r_im_q;
  logic signed [RW-1:0]    r_re_acc;
  logic signed [RW-1:0]    r_im_acc;
  logic signed [RW-1:0]    r_re_res;
  logic signed [RW-1:0]    r_im_res;
  logic                    r_done;

  logic signed [WIDTH-1:0] w_mul_a;
  logic signed [WIDTH-1:0] w_mul_b;
  logic signed [PW-1:0]    w_prod;

  // Operand selection for the partial product issued in each state.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      M0: begin w_mul_a = r_re_a; w_mul_b = r_re_q; end
      M1: begin w_mul_a = r_im_a; w_mul_b = r_im_q; end
      M2: begin w_mul_a = r_re_a; w_mul_b = r_im_q; end
      M3: begin w_mul_a = r_im_a; w_mul_b = r_re_q; end
      default: begin w_mul_a = '0; w_mul_b = '0; end
    endcase
  end

  mult_unit #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_p     (w_prod)
  );

  // Each state consumes the product issued one state earlier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_re_a   <= '0;
      r_im_a   <= '0;
      r_re_q   <= '0;
      r_im_q   <= '0;
      r_re_acc <= '0;
      r_im_acc <= '0;
      r_re_res <= '0;
      r_im_res <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_re_a  <= re_a;
            r_im_a  <= im_a;
            r_re_q  <= re_q;
            r_im_q  <= im_q;
            r_state <= M0;
          end
        end
        M0: r_state <= M1;
        M1: begin
          r_re_acc <= RW'(w_prod);
          r_state  <= M2;
        end
        M2: begin
          r_re_acc <= r_re_acc - RW'(w_prod);
          r_state  <= M3;
        end
        M3: begin
          r_im_acc <= RW'(w_prod);
          r_state  <= FIN;
        end
        FIN: begin
          r_re_res <= r_re_acc;
          r_im_res <= r_im_acc + RW'(w_prod);
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign re_res = r_re_res;
  assign im_res = r_im_res;

endmodule
